// File: rtl/cart_cpu_bus_bridge.sv
// cart_cpu_bus_bridge: cartridge-side CPU bus front end.
// Classifies each CPU access, strobes mapper register writes, and runs the
// PRG ROM/RAM request/ack handshake with a bounded wait. Also keeps the
// open-bus value and registers the active-low CPU IRQ.
// Optional feature: define CART_BUS_RMW_FILTER_EN to suppress the second of
// two back-to-back mapper register writes (6502 read-modify-write dummy write).
module cart_cpu_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpu_req_i,
  input  logic        cpu_wr_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_wr_data_i,
  output logic        cpu_ack_o,
  output logic [7:0]  cpu_rd_data_o,
  output logic        busy_o,
  output logic        mapper_wr_o,
  output logic [14:0] mapper_addr_o,
  output logic [7:0]  mapper_wr_data_o,
  output logic [14:0] prg_rom_addr_o,
  output logic [12:0] prg_ram_addr_o,
  input  logic        prg_ram_en_i,
  input  logic        prg_ram_wr_en_i,
  input  logic        mapper_irq_i,
  output logic        mem_req_o,
  output logic        mem_sel_o,
  output logic        mem_wr_o,
  output logic [7:0]  mem_wr_data_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rd_data_i,
  output logic        timeout_o,
  output logic        cpu_irq_n_o
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_ACK} state_e;
  typedef enum logic [2:0] {K_OPEN, K_MAPPER_WR, K_ROM_RD, K_RAM_RD, K_RAM_WR, K_DROP} kind_e;

  // Last counter value before the wait is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d, dec_kind;
  logic        wr_q, wr_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  open_q, open_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        irq_n_q;
  logic        accept;

  assign accept = (state_q == S_IDLE) && cpu_req_i;

  // Classify the access presented on the CPU bus.
  always_comb begin
    dec_kind = K_OPEN;
    if (cpu_addr_i[15]) begin
      dec_kind = cpu_wr_i ? K_MAPPER_WR : K_ROM_RD;
    end else if (cpu_addr_i[14:13] == 2'b11) begin
      if (cpu_wr_i) dec_kind = (prg_ram_en_i && prg_ram_wr_en_i) ? K_RAM_WR : K_DROP;
      else          dec_kind = prg_ram_en_i ? K_RAM_RD : K_OPEN;
    end
  end

  // Access sequencer: next state and datapath updates.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    open_d  = open_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          kind_d  = dec_kind;
          wr_d    = cpu_wr_i;
          addr_d  = cpu_addr_i[14:0];
          wdata_d = cpu_wr_data_i;
          // Non-memory reads return the open-bus value unchanged.
          rdata_d = open_q;
          cnt_d   = 8'd0;
          if (dec_kind == K_ROM_RD || dec_kind == K_RAM_RD || dec_kind == K_RAM_WR)
            state_d = S_MEM;
          else
            state_d = S_ACK;
        end
      end
      S_MEM: begin
        // An ack in the final counted cycle takes priority over the timeout.
        if (mem_ack_i) begin
          rdata_d = mem_rd_data_i;
          state_d = S_ACK;
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          rdata_d = open_q;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (wr_q)                  open_d = wdata_q;
        else if (kind_q != K_OPEN) open_d = rdata_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      kind_q  <= K_OPEN;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      open_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      open_q  <= open_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // IRQ resynchronised to active-low, independent of the sequencer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_n_q <= 1'b1;
    else          irq_n_q <= ~mapper_irq_i;
  end

`ifdef CART_BUS_RMW_FILTER_EN
  logic prev_mwr_q, filt_q;

  // Remember whether the previous accepted request was a mapper write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_mwr_q <= 1'b0;
      filt_q     <= 1'b0;
    end else if (accept) begin
      prev_mwr_q <= (dec_kind == K_MAPPER_WR);
      filt_q     <= (dec_kind == K_MAPPER_WR) && prev_mwr_q;
    end
  end

  assign mapper_wr_o = (state_q == S_ACK) && (kind_q == K_MAPPER_WR) && !filt_q;
`else
  assign mapper_wr_o = (state_q == S_ACK) && (kind_q == K_MAPPER_WR);
`endif

  assign cpu_ack_o        = (state_q == S_ACK);
  assign cpu_rd_data_o    = rdata_q;
  assign busy_o           = (state_q != S_IDLE);
  assign mapper_addr_o    = addr_q;
  assign mapper_wr_data_o = wdata_q;
  assign prg_rom_addr_o   = addr_q;
  assign prg_ram_addr_o   = addr_q[12:0];
  assign mem_req_o        = (state_q == S_MEM);
  assign mem_sel_o        = mem_req_o && (kind_q == K_RAM_RD || kind_q == K_RAM_WR);
  assign mem_wr_o         = mem_req_o && (kind_q == K_RAM_WR);
  assign mem_wr_data_o    = wdata_q;
  assign timeout_o        = to_q;
  assign cpu_irq_n_o      = irq_n_q;

endmodule

// File: tb/tb_cart_cpu_bus_bridge.sv
// Scoreboard bench for cart_cpu_bus_bridge (built with TIMEOUT_CYCLES=4).
module tb_cart_cpu_bus_bridge;

`ifdef CART_BUS_RMW_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack, busy, mapper_wr, mem_req, mem_sel, mem_wr, timeout, cpu_irq_n;
  logic [7:0]  cpu_rdata, mapper_wdata, mem_wdata;
  logic [14:0] mapper_addr, prg_rom_addr;
  logic [12:0] prg_ram_addr;
  logic        ram_en = 1'b1, ram_wr_en = 1'b0, mapper_irq = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;

  cart_cpu_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wr_data_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rd_data_o(cpu_rdata), .busy_o(busy),
    .mapper_wr_o(mapper_wr), .mapper_addr_o(mapper_addr), .mapper_wr_data_o(mapper_wdata),
    .prg_rom_addr_o(prg_rom_addr), .prg_ram_addr_o(prg_ram_addr),
    .prg_ram_en_i(ram_en), .prg_ram_wr_en_i(ram_wr_en), .mapper_irq_i(mapper_irq),
    .mem_req_o(mem_req), .mem_sel_o(mem_sel), .mem_wr_o(mem_wr), .mem_wr_data_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rd_data_i(mem_rdata),
    .timeout_o(timeout), .cpu_irq_n_o(cpu_irq_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          chk_rd;
    logic [7:0]  rd;
    bit          mwr;
    logic [14:0] addr;
    logic [7:0]  wd;
    bit          to;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on every ack.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_while_busy", 32'(cpu_req & busy), 32'd0);
      chk("mwr_without_ack", 32'(mapper_wr & ~cpu_ack), 32'd0);
      if (cpu_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
          if (mon_e.chk_rd) chk("rd_data", 32'(cpu_rdata), 32'(mon_e.rd));
          chk("mapper_wr", 32'(mapper_wr), 32'(mon_e.mwr));
          chk("mapper_addr", 32'(mapper_addr), 32'(mon_e.addr));
          if (mon_e.mwr) chk("mapper_wr_data", 32'(mapper_wdata), 32'(mon_e.wd));
          chk("timeout_at_ack", 32'(timeout), 32'(mon_e.to));
          chk("busy_at_ack", 32'(busy), 32'd1);
        end
      end
    end
  end

  // Present one request for one cycle; optionally push its expected response.
  task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] d, input bit push,
                       input bit chk_rd, input logic [7:0] rd, input bit mwr, input bit to,
                       input int lat);
    exp_t e;
    @(posedge clk); #1;
    e.chk_rd = chk_rd; e.rd = rd; e.mwr = mwr; e.addr = a[14:0];
    e.wd = d; e.to = to; e.cyc = cyc + lat;
    if (push) q.push_back(e);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // Memory answers d cycles after the first mem_req cycle.
  task automatic mem_respond(input int d, input logic [7:0] data);
    repeat (d) begin @(posedge clk); #1; end
    mem_ack = 1'b1; mem_rdata = data;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    chk("mem_req_after_ack", 32'(mem_req), 32'd0);
    chk("cpu_ack_after_mem", 32'(cpu_ack), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_rd_data"}, 32'(cpu_rdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mapper_wr"}, 32'(mapper_wr), 32'd0);
    chk({tag, "_mapper_addr"}, 32'(mapper_addr), 32'd0);
    chk({tag, "_mapper_wdata"}, 32'(mapper_wdata), 32'd0);
    chk({tag, "_rom_addr"}, 32'(prg_rom_addr), 32'd0);
    chk({tag, "_ram_addr"}, 32'(prg_ram_addr), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_sel"}, 32'(mem_sel), 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_irq_n"}, 32'(cpu_irq_n), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Mapper register write: ack and strobe one cycle after acceptance.
    issue(1'b1, 16'h8001, 8'h46, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1);
    chk("mwr_strobe_n1", 32'(mapper_wr), 32'd1);
    chk("mwr_no_mem_req", 32'(mem_req), 32'd0);
    chk("mwr_ack_n1", 32'(cpu_ack), 32'd1);

    // ROM read, ack in the 4th mem_req cycle (last counted cycle beats timeout).
    issue(1'b0, 16'hC123, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 5);
    chk("rom_mem_req", 32'(mem_req), 32'd1);
    chk("rom_addr", 32'(prg_rom_addr), 32'h4123);
    chk("rom_sel", 32'(mem_sel), 32'd0);
    chk("rom_mem_wr", 32'(mem_wr), 32'd0);
    mem_respond(3, 8'hA5);

    // RAM write with write-enable off is dropped; open bus takes the data.
    issue(1'b1, 16'h6000, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    chk("drop_no_mem_req", 32'(mem_req), 32'd0);
    chk("drop_ack_n1", 32'(cpu_ack), 32'd1);
    issue(1'b0, 16'h5000, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1);

    // RAM write, zero-wait memory.
    ram_wr_en = 1'b1;
    issue(1'b1, 16'h7FFF, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2);
    chk("ramwr_mem_req", 32'(mem_req), 32'd1);
    chk("ramwr_sel", 32'(mem_sel), 32'd1);
    chk("ramwr_mem_wr", 32'(mem_wr), 32'd1);
    chk("ramwr_wdata", 32'(mem_wdata), 32'h77);
    chk("ramwr_addr", 32'(prg_ram_addr), 32'h1FFF);
    mem_respond(0, 8'h00);

    // RAM read, one wait cycle.
    issue(1'b0, 16'h6010, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 3);
    chk("ramrd_sel", 32'(mem_sel), 32'd1);
    chk("ramrd_mem_wr", 32'(mem_wr), 32'd0);
    chk("ramrd_addr", 32'(prg_ram_addr), 32'h0010);
    mem_respond(1, 8'h3C);

    // RAM read with RAM disabled is open bus.
    ram_en = 1'b0;
    issue(1'b0, 16'h6000, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1);
    chk("ramdis_no_mem_req", 32'(mem_req), 32'd0);
    ram_en = 1'b1;

    // Timeout: mem_req for exactly 4 cycles, then ack with open-bus data.
    issue(1'b0, 16'h8000, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 5);
    chk("to_mem_req_c1", 32'(mem_req), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("to_mem_req_c%0d", k), 32'(mem_req), 32'd1);
      chk($sformatf("to_flag_early_c%0d", k), 32'(timeout), 32'd0);
    end
    @(posedge clk); #1;
    chk("to_mem_req_dropped", 32'(mem_req), 32'd0);
    chk("to_flag_set", 32'(timeout), 32'd1);
    chk("to_ack", 32'(cpu_ack), 32'd1);

    // Back-to-back mapper writes; timeout flag stays sticky.
    issue(1'b1, 16'h8000, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1);
    issue(1'b1, 16'h8000, 8'h02, 1'b1, 1'b0, 8'h00, !FILT, 1'b1, 1);
    issue(1'b0, 16'h4020, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1);
    issue(1'b1, 16'h8000, 8'h03, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1);

    // IRQ: one-cycle lag, inverted.
    @(posedge clk); #1;
    mapper_irq = 1'b1;
    chk("irq_n_before_edge", 32'(cpu_irq_n), 32'd1);
    @(posedge clk); #1;
    chk("irq_n_after_edge", 32'(cpu_irq_n), 32'd0);

    // Reset in the middle of a memory access: immediate abort, no ack.
    issue(1'b0, 16'h9000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    chk("abort_mem_req_pre", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_irq_n", 32'(cpu_irq_n), 32'd0);
    chk("post_reset_no_ack", 32'(cpu_ack), 32'd0);

    // Open-bus latch was cleared by reset.
    issue(1'b0, 16'h4000, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
